// File: rtl/pwm_pkg.sv
// Shared constants and the per-bit output select for the PWM peripheral.
// Pure definitions: no state, no latency.
package pwm_pkg;

    localparam int          NUM_OUT          = 16;
    localparam int          PWM_PERIOD_TICKS = 255;
    localparam logic [7:0]  PWM_CNT_MAX      = 8'd254;
    localparam logic [7:0]  DUTY_FULL        = 8'hFF;
    localparam int          DEFAULT_CLK_DIV  = 3000;

    // Disabled bits are forced low; enabled non-PWM bits are static high.
    function automatic logic [NUM_OUT-1:0] out_select(
        input logic [NUM_OUT-1:0] en_out,
        input logic [NUM_OUT-1:0] en_pwm,
        input logic               pwm_raw
    );
        logic [NUM_OUT-1:0] sel;
        sel = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (!en_out[i])
                sel[i] = 1'b0;
            else if (!en_pwm[i])
                sel[i] = 1'b1;
            else
                sel[i] = pwm_raw;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler: emits a combinational one-clk tick every CLK_DIV clocks.
// Latency: first tick CLK_DIV-1 clocks after reset release; tick is combinational from the count.
// Backpressure: none, free-running.
module pwm_tick_gen #(
    parameter int CLK_DIV = 3000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int               DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] LAST  = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] prescaler;

    always_ff @(posedge clk) begin
        if (rst)
            prescaler <= '0;
        else if (prescaler == LAST)
            prescaler <= '0;
        else
            prescaler <= prescaler + 1'b1;
    end

    assign tick = (prescaler == LAST);

endmodule

// File: rtl/pwm_peripheral.sv
// Drives 16 outputs low, static high, or from one shared 8-bit PWM waveform.
// Latency: enables reach out 1 clk later; duty takes effect only at the next period boundary.
// Backpressure: none; config inputs are level-sampled every clock.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        pwm_period_start
);

    logic               tick;
    logic [7:0]         pwm_cnt;
    logic [7:0]         duty_shadow;
    logic               period_wrap;
    logic               pwm_raw;
    logic [NUM_OUT-1:0] en_out;
    logic [NUM_OUT-1:0] en_pwm;
    logic [NUM_OUT-1:0] out_nxt;

    pwm_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign en_out      = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm      = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign period_wrap = tick && (pwm_cnt == PWM_CNT_MAX);

    // Full-scale duty is special-cased so 0xFF has no one-tick low gap.
    assign pwm_raw = (duty_shadow == DUTY_FULL) || (pwm_cnt < duty_shadow);
    assign out_nxt = out_select(en_out, en_pwm, pwm_raw);

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt          <= '0;
            duty_shadow      <= '0;
            pwm_period_start <= 1'b0;
            out              <= '0;
        end else begin
            if (period_wrap) begin
                pwm_cnt     <= '0;
                duty_shadow <= pwm_duty_cycle;
            end else if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
            pwm_period_start <= period_wrap;
            out              <= out_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral at CLK_DIV=4: static table, hand-built period sequences, random stimulus.
// Expected outputs come from an arithmetic model indexed by clocks since reset release.
module tb_pwm_peripheral;

    localparam int CLK_DIV = 4;
    localparam int PERIOD  = 255 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;
    logic        pwm_period_start;

    int          vectors     = 0;
    int          miscompares = 0;

    // model state: clock edges since reset release, duty of the running period
    int          m_n      = 0;
    logic [7:0]  m_shadow = 8'h00;
    logic [15:0] exp_out;
    logic        exp_strobe;

    typedef struct {
        logic [15:0] en_out;
        logic [15:0] en_pwm;
        logic [15:0] exp_out;
    } vec_t;

    vec_t tv[8];

    pwm_peripheral #(.CLK_DIV(CLK_DIV)) dut (
        .clk              (clk),
        .rst              (rst),
        .en_reg_out_7_0   (en_reg_out_7_0),
        .en_reg_out_15_8  (en_reg_out_15_8),
        .en_reg_pwm_7_0   (en_reg_pwm_7_0),
        .en_reg_pwm_15_8  (en_reg_pwm_15_8),
        .pwm_duty_cycle   (pwm_duty_cycle),
        .out              (out),
        .pwm_period_start (pwm_period_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
        {en_reg_out_15_8, en_reg_out_7_0} = eo;
        {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
    endtask

    // One clock: predict from the model, advance, then compare away from the edge.
    task automatic step();
        int          cnt;
        logic        raw;
        logic [15:0] eo, ep;
        cnt = (m_n / CLK_DIV) % 255;
        raw = (m_shadow == 8'hFF) || (cnt < int'(m_shadow));
        eo  = {en_reg_out_15_8, en_reg_out_7_0};
        ep  = {en_reg_pwm_15_8, en_reg_pwm_7_0};
        if (rst) begin
            exp_out    = 16'h0000;
            exp_strobe = 1'b0;
            m_n        = 0;
            m_shadow   = 8'h00;
        end else begin
            for (int i = 0; i < 16; i++)
                exp_out[i] = !eo[i] ? 1'b0 : (!ep[i] ? 1'b1 : raw);
            m_n++;
            exp_strobe = (m_n % PERIOD == 0);
            if (exp_strobe)
                m_shadow = pwm_duty_cycle;
        end
        @(posedge clk);
        #1;
        check("model_out", {16'h0, out}, {16'h0, exp_out});
        check("model_strobe", {31'h0, pwm_period_start}, {31'h0, exp_strobe});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        check("reset_out", {16'h0, out}, 32'h0);
        check("reset_strobe", {31'h0, pwm_period_start}, 32'h0);
        rst = 1'b0;
    endtask

    // Runs one full period starting just after a strobe; counts all-high and all-low clocks.
    task automatic window(input string name, input logic [7:0] start_duty,
                          input int mid_step, input logic [7:0] mid_duty, input int exp_high);
        int hi = 0;
        int lo = 0;
        pwm_duty_cycle = start_duty;
        for (int k = 0; k < PERIOD; k++) begin
            if (k == mid_step)
                pwm_duty_cycle = mid_duty;
            step();
            if (out == 16'hFFFF)
                hi++;
            else if (out == 16'h0000)
                lo++;
        end
        check({name, "_high"}, hi, exp_high);
        check({name, "_low"}, lo, PERIOD - exp_high);
        check({name, "_end_strobe"}, {31'h0, pwm_period_start}, 32'h1);
    endtask

    initial begin
        int strobes;
        int first_strobe;
        int found;

        tv[0] = '{16'h0000, 16'h0000, 16'h0000};
        tv[1] = '{16'h00FF, 16'h0000, 16'h00FF};
        tv[2] = '{16'hFFFF, 16'hFFFF, 16'h0000};
        tv[3] = '{16'hFFFF, 16'h0F0F, 16'hF0F0};
        tv[4] = '{16'hA5A5, 16'h0000, 16'hA5A5};
        tv[5] = '{16'h0000, 16'hFFFF, 16'h0000};
        tv[6] = '{16'h1234, 16'h0030, 16'h1204};
        tv[7] = '{16'hFFFF, 16'h8001, 16'h7FFE};

        rst = 1'b1;
        set_en(16'h0000, 16'h0000);
        pwm_duty_cycle = 8'h80;

        // all enables off: outputs stay low, strobe every period from release
        do_reset();
        strobes      = 0;
        first_strobe = -1;
        for (int k = 1; k <= 3 * PERIOD; k++) begin
            step();
            if (pwm_period_start) begin
                strobes++;
                if (first_strobe < 0)
                    first_strobe = k;
            end
        end
        check("t1_strobe_count", strobes, 3);
        check("t1_first_strobe", first_strobe, PERIOD);

        // static enable table, applied inside the duty-0 first period
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_en(tv[i].en_out, tv[i].en_pwm);
            step();
            check($sformatf("table_%0d", i), {16'h0, out}, {16'h0, tv[i].exp_out});
        end

        // all PWM, walk through duty corner values period by period
        set_en(16'hFFFF, 16'hFFFF);
        pwm_duty_cycle = 8'h40;
        found = 0;
        for (int k = 0; k < PERIOD + 50 && found == 0; k++) begin
            step();
            if (pwm_period_start)
                found = 1;
        end
        check("wait_strobe", found, 1);
        window("duty40",      8'h00, -1,  8'h00, 256);
        window("duty00",      8'hFF, -1,  8'hFF, 0);
        window("dutyFF",      8'h01, -1,  8'h01, PERIOD);
        window("duty01",      8'h40, -1,  8'h40, 4);
        window("duty40_mid",  8'h40, 500, 8'hC0, 256);
        window("dutyC0",      8'hC0, -1,  8'hC0, 768);

        // reset mid-period while outputs are high
        for (int k = 0; k < 100; k++)
            step();
        check("t6_pre_high", {16'h0, out}, 32'h0000FFFF);
        rst = 1'b1;
        step();
        check("t6_rst_out", {16'h0, out}, 32'h0);
        check("t6_rst_strobe", {31'h0, pwm_period_start}, 32'h0);
        rst = 1'b0;
        window("t6_after_rst", 8'hC0, -1, 8'hC0, 0);
        window("t6_resume",    8'hC0, -1, 8'hC0, 768);

        // random enables, duty changes and occasional resets against the model
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 199) == 0)
                set_en(16'($urandom), 16'($urandom));
            if ($urandom_range(0, 299) == 0)
                pwm_duty_cycle = 8'($urandom);
            rst = ($urandom_range(0, 1499) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
